reg_arith_sequencer: RTL and testbench

Multi-cycle execute controller for RV32I register-register arithmetic (OP opcode). It accepts one decoded instruction at a time over a valid/ready handshake, classifies it by funct3/funct7 into a `reg_arith_kind_t`, and sequences the computation: single-cycle ALU ops, or a serial one-bit-per-cycle shifter for SLL/SRL/SRA. It then holds the result on a writeback handshake until the register-file write port accepts it. It sits between the issue stage and register-file writeback in the core.

---
 rtl/reg_arith_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_reg_arith_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_arith_sequencer.sv
// reg_arith_sequencer: multi-cycle execute controller for RV32I OP-opcode
// arithmetic. It takes one instruction at a time. Most ops finish in one
// ALU cycle. SLL/SRL/SRA run on a serial one-bit-per-cycle shifter. The
// result is held on a writeback handshake until the register file takes it.
module reg_arith_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic            flush,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_result,
  output logic            wb_we,
  output logic            wb_illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_SHIFT, S_DONE
  } state_t;

  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
    K_INVALID
  } reg_arith_kind_t;

  state_t            r_state, w_next;
  reg_arith_kind_t   r_kind;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_rs2;
  logic [XLEN-1:0]   r_result;
  logic [SHW-1:0]    r_cnt;
  logic              r_illegal;
  logic              w_is_shift;
  logic [SHW-1:0]    w_shamt;

  // Decode funct3/funct7. Only ADD/SUB and SRL/SRA look at funct7.
  function automatic reg_arith_kind_t classify(input logic [2:0] f3,
                                               input logic [6:0] f7);
    reg_arith_kind_t k;
    k = K_INVALID;
    case (f3)
      3'b000: begin
        if (f7 == 7'b0000000)      k = K_ADD;
        else if (f7 == 7'b0100000) k = K_SUB;
      end
      3'b001: k = K_SLL;
      3'b010: k = K_SLT;
      3'b011: k = K_SLTU;
      3'b100: k = K_XOR;
      3'b101: begin
        if (f7 == 7'b0000000)      k = K_SRL;
        else if (f7 == 7'b0100000) k = K_SRA;
      end
      3'b110: k = K_OR;
      3'b111: k = K_AND;
      default: k = K_INVALID;
    endcase
    return k;
  endfunction

  // Single-cycle ALU result. Shifts and invalid ops return 0 here because
  // they are handled elsewhere.
  function automatic logic [XLEN-1:0] alu(input reg_arith_kind_t k,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (k)
      K_ADD:  r = a + b;
      K_SUB:  r = a - b;
      K_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      K_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      K_XOR:  r = a ^ b;
      K_OR:   r = a | b;
      K_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One step of the serial shifter.
  function automatic logic [XLEN-1:0] shift_step(input reg_arith_kind_t k,
                                                 input logic [XLEN-1:0] acc);
    logic [XLEN-1:0] r;
    r = acc;
    case (k)
      K_SLL:   r = {acc[XLEN-2:0], 1'b0};
      K_SRL:   r = {1'b0, acc[XLEN-1:1]};
      K_SRA:   r = {acc[XLEN-1], acc[XLEN-1:1]};
      default: r = acc;
    endcase
    return r;
  endfunction

  assign w_is_shift = (r_kind == K_SLL) || (r_kind == K_SRL) || (r_kind == K_SRA);
  assign w_shamt    = r_rs2[SHW-1:0];

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign wb_valid   = (r_state == S_DONE);
  assign wb_rd      = r_rd;
  assign wb_result  = r_result;
  assign wb_illegal = r_illegal;
  assign wb_we      = wb_valid && !r_illegal && (r_rd != 5'd0);

  // State register: reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: flush outranks all normal transitions.
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid) w_next = S_EXEC;
        S_EXEC:  w_next = (w_is_shift && (w_shamt != '0)) ? S_SHIFT : S_DONE;
        S_SHIFT: if (r_cnt == SHW'(1)) w_next = S_DONE;
        S_DONE:  if (wb_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Operand capture, execute and shift datapath. Visible outputs are
  // cleared on reset so a lost result never leaks onto the writeback bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kind    <= K_INVALID;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_kind <= classify(in_funct3, in_funct7);
            r_rd   <= in_rd;
            r_rs1  <= in_rs1_val;
            r_rs2  <= in_rs2_val;
          end
        end
        S_EXEC: begin
          r_illegal <= (r_kind == K_INVALID);
          if (w_is_shift) begin
            r_result <= r_rs1;
            r_cnt    <= w_shamt;
          end else begin
            r_result <= alu(r_kind, r_rs1, r_rs2);
            r_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          r_result <= shift_step(r_kind, r_result);
          r_cnt    <= r_cnt - SHW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_arith_sequencer.sv
// Self-checking bench for reg_arith_sequencer: scoreboard of expected
// writebacks built from a behavioural model of the RV32I reg-arith ops.
module tb_reg_arith_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        wb_we;
  logic        wb_illegal;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        ill;
    logic        we;
    int          lat;
  } exp_t;

  exp_t sb[$];

  reg_arith_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_result(wb_result), .wb_we(wb_we), .wb_illegal(wb_illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural reference: whole-word shifts, latency from the op class.
  function automatic void model(input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill,
                                output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = 32'd0;
    ill = 1'b0;
    lat = 2;
    case (f3)
      3'b000: if (f7 == 7'h00) r = a + b;
              else if (f7 == 7'h20) r = a - b;
              else ill = 1'b1;
      3'b001: begin r = a << sh; lat = 2 + sh; end
      3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: r = (a < b) ? 32'd1 : 32'd0;
      3'b100: r = a ^ b;
      3'b101: begin
        if (f7 == 7'h00) begin r = a >> sh; lat = 2 + sh; end
        else if (f7 == 7'h20) begin r = 32'($signed(a) >>> sh); lat = 2 + sh; end
        else ill = 1'b1;
      end
      3'b110: r = a | b;
      default: r = a & b;
    endcase
  endfunction

  // Drive one instruction from a negedge; returns just after the accept edge
  // with operands scrambled to show they are sampled only at that edge.
  task automatic issue(input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input bit push);
    exp_t e;
    model(f3, f7, a, b, e.res, e.ill, e.lat);
    e.rd = rd;
    e.we = !e.ill && (rd != 5'd0);
    if (push) sb.push_back(e);
    in_funct3 = f3; in_funct7 = f7; in_rd = rd;
    in_rs1_val = a; in_rs2_val = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_rs1_val = $urandom; in_rs2_val = $urandom;
    in_rd = 5'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
  endtask

  // Wait (bounded) for wb_valid; lat counts edges from the accept edge.
  task automatic wait_wb(output int lat, output bit timeout);
    lat = 1;
    timeout = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (wb_valid) begin timeout = 1'b0; break; end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, wb_valid, wb_we, wb_illegal, busy} !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got rdy/vld/we/ill/busy=%b want 10000",
               {in_ready, wb_valid, wb_we, wb_illegal, busy});
    end
    n_checks++;
    if (wb_rd !== 5'd0 || wb_result !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_data: got rd=%0d res=%h want 0/0", wb_rd, wb_result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  localparam int NA = 14;
  logic [2:0]  t_f3  [NA] = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd7,
                              3'd5, 3'd5, 3'd1, 3'd0, 3'd0, 3'd1};
  logic [6:0]  t_f7  [NA] = '{7'h00, 7'h20, 7'h55, 7'h00, 7'h00, 7'h7F, 7'h00, 7'h00,
                              7'h20, 7'h00, 7'h00, 7'h01, 7'h00, 7'h7F};
  logic [4:0]  t_rd  [NA] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8,
                              5'd9, 5'd10, 5'd11, 5'd12, 5'd0, 5'd13};
  logic [31:0] t_rs1 [NA] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000,
                              32'hF0F0F0F0, 32'h12345678, 32'hF0F0F0F0, 32'hF0F0F0F0,
                              32'h80000000, 32'h80000000, 32'h00000001, 32'h00000005,
                              32'h00000007, 32'h00000003};
  logic [31:0] t_rs2 [NA] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001,
                              32'h0FF00FF0, 32'h12345678, 32'h0FF00FF0, 32'h0FF00FF0,
                              32'h0000003F, 32'h0000003F, 32'h00000000, 32'h00000003,
                              32'h00000009, 32'h00000004};

  task automatic test_alu;
    exp_t e;
    int   lat;
    bit   to;
    wb_ready = 1'b1;
    for (int i = 0; i < NA; i++) begin
      issue(t_f3[i], t_f7[i], t_rd[i], t_rs1[i], t_rs2[i], 1'b1);
      wait_wb(lat, to);
      e = sb.pop_front();
      n_checks++;
      if (to) begin
        n_errors++;
        $display("FAIL alu%0d_timeout: no wb_valid within bound, want at %0d", i, e.lat);
      end else begin
        if (lat != e.lat) begin
          n_errors++;
          $display("FAIL alu%0d_latency: got %0d want %0d", i, lat, e.lat);
        end
        n_checks++;
        if (wb_result !== e.res) begin
          n_errors++;
          $display("FAIL alu%0d_result: got %h want %h", i, wb_result, e.res);
        end
        n_checks++;
        if (wb_rd !== e.rd || wb_illegal !== e.ill || wb_we !== e.we || busy !== 1'b1) begin
          n_errors++;
          $display("FAIL alu%0d_flags: got rd=%0d ill=%b we=%b busy=%b want rd=%0d ill=%b we=%b busy=1",
                   i, wb_rd, wb_illegal, wb_we, busy, e.rd, e.ill, e.we);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   lat;
    bit   to;
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b%0d_ready: got in_ready=%b busy=%b want 1/0", i, in_ready, busy);
      end
      issue(3'd0, 7'h00, 5'(20 + i), 32'(i * 1000), 32'h00000011, 1'b1);
      wait_wb(lat, to);
      e = sb.pop_front();
      n_checks++;
      if (to || lat != 2 || wb_result !== e.res) begin
        n_errors++;
        $display("FAIL b2b%0d_result: got lat=%0d res=%h want lat=2 res=%h", i, lat, wb_result, e.res);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int   lat;
    bit   to;
    wb_ready = 1'b0;
    issue(3'd4, 7'h00, 5'd9, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b1);
    wait_wb(lat, to);
    e = sb.pop_front();
    n_checks++;
    if (to || wb_result !== e.res) begin
      n_errors++;
      $display("FAIL bp_first: got to=%b res=%h want res=%h", to, wb_result, e.res);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b1 || wb_result !== e.res || in_ready !== 1'b0 || wb_rd !== e.rd) begin
        n_errors++;
        $display("FAIL bp_hold%0d: got vld=%b res=%h rdy=%b rd=%0d want 1/%h/0/%0d",
                 c, wb_valid, wb_result, in_ready, wb_rd, e.res, e.rd);
      end
    end
    wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b want 0/1", wb_valid, in_ready);
    end
  endtask

  task automatic test_flush;
    bit seen;
    wb_ready = 1'b1;
    issue(3'd1, 7'h00, 5'd14, 32'h00000001, 32'd20, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_pre: got busy=%b vld=%b want 1/0", busy, wb_valid);
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_idle: got busy=%b rdy=%b vld=%b want 0/1/0", busy, in_ready, wb_valid);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wb_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL flush_no_wb: got wb_valid=1 after flush want never");
    end
    // flush together with in_valid in IDLE: the offer is ignored
    in_valid = 1'b1; flush = 1'b1;
    in_funct3 = 3'd0; in_funct7 = 7'h00; in_rd = 5'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_idle_accept: got busy=%b rdy=%b want 0/1", busy, in_ready);
    end
  endtask

  task automatic test_rst_mid_shift;
    wb_ready = 1'b1;
    issue(3'd5, 7'h20, 5'd7, 32'h80000000, 32'h0000001F, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, wb_valid, wb_we, wb_illegal, busy} !== 5'b10000 ||
        wb_rd !== 5'd0 || wb_result !== 32'd0) begin
      n_errors++;
      $display("FAIL rst_mid_shift: got rdy/vld/we/ill/busy=%b rd=%0d res=%h want 10000/0/0",
               {in_ready, wb_valid, wb_we, wb_illegal, busy}, wb_rd, wb_result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    in_funct3 = '0; in_funct7 = '0; in_rd = '0;
    in_rs1_val = '0; in_rs2_val = '0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_rst_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
